// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit and the control unit.
// Holds the FUNCT3 op codes, the unit's state encoding, the latched
// per-operation context and small helpers that classify op signedness.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Context latched at acceptance: op plus the signs of the original operands
    typedef struct packed {
        funct3_e funct3;
        logic    neg_a;
        logic    neg_b;
    } op_ctx_t;

    // rs1 is interpreted as signed
    function automatic logic op1_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op2_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // Divide/remainder family (FUNCT3[2] set)
    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational result finishing for muldiv_unit.
// Takes the unsigned 2*XLEN accumulator (product, or {remainder, quotient})
// and the latched op context, applies two's-complement sign correction and
// selects the half / quotient / remainder the op asks for.
// Ports:
//   ctx      - latched op and operand signs
//   acc      - final iteration accumulator
//   result_c - finished XLEN-bit result (combinational)
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  op_ctx_t               ctx,
    input  logic [2*XLEN-1:0]     acc,
    output logic [XLEN-1:0]       result_c
);

    localparam int unsigned AW = 2 * XLEN;

    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    // Product negative iff exactly one signed operand was negative; quotient
    // likewise; remainder follows the dividend.
    always_comb begin
        prod     = (ctx.neg_a ^ ctx.neg_b) ? (~acc + AW'(1)) : acc;
        quot     = (ctx.neg_a ^ ctx.neg_b) ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
        rem      = ctx.neg_a ? (~acc[AW-1:XLEN] + XLEN'(1)) : acc[AW-1:XLEN];
        result_c = prod[XLEN-1:0];
        case (ctx.funct3)
            OP_MUL:                       result_c = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_c = prod[AW-1:XLEN];
            OP_DIV, OP_DIVU:              result_c = quot;
            OP_REM, OP_REMU:              result_c = rem;
            default:                      result_c = prod[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on unsigned magnitudes over a
// 2*XLEN-bit accumulator, one iteration per clock, then a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in
// one edge.
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   START, FUNCT3         - request and op code, sampled with the operands
//   OPERAND1, OPERAND2    - rs1 / rs2
//   FLUSH                 - abandon any in-flight op
//   BUSY                  - op in progress (CALC/FIX)
//   RESULT_VALID, RESULT  - one-cycle completion pulse and held result
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned AW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    op_ctx_t         ctx_q, ctx_d;
    logic [XLEN-1:0] result_d;
    logic            valid_d;
    logic            busy_d;

    logic            neg1_c, neg2_c;
    logic [XLEN-1:0] mag1_c, mag2_c;
    logic            div_zero_c, div_ovf_c;
    logic [XLEN:0]   mul_sum_c;
    logic [XLEN:0]   div_diff_c;
    logic [AW-1:0]   mul_step_c, div_step_c;
    logic [XLEN-1:0] fix_result_c;

    // Operand classification and magnitude conversion at acceptance
    always_comb begin
        neg1_c     = op1_signed(FUNCT3) & OPERAND1[XLEN-1];
        neg2_c     = op2_signed(FUNCT3) & OPERAND2[XLEN-1];
        mag1_c     = neg1_c ? (~OPERAND1 + XLEN'(1)) : OPERAND1;
        mag2_c     = neg2_c ? (~OPERAND2 + XLEN'(1)) : OPERAND2;
        div_zero_c = is_div(FUNCT3) && (OPERAND2 == '0);
        div_ovf_c  = ((FUNCT3 == OP_DIV) || (FUNCT3 == OP_REM)) &&
                     (OPERAND1 == MOST_NEG) && (OPERAND2 == '1);
    end

    // One iteration step. Multiply: low half holds the remaining multiplier
    // bits, add multiplicand into the high half on a 1 and shift right with
    // carry. Divide: shift left, trial-subtract the divisor from the top
    // XLEN+1 bits, keep the difference and shift in a 1 when no borrow.
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
        mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
        div_diff_c = acc_q[AW-1:XLEN-1] - {1'b0, opb_q};
        if (!div_diff_c[XLEN]) begin
            div_step_c = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_step_c = {acc_q[AW-2:0], 1'b0};
        end
    end

    muldiv_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .ctx      (ctx_q),
        .acc      (acc_q),
        .result_c (fix_result_c)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        ctx_d    = ctx_q;
        result_d = RESULT;
        valid_d  = 1'b0;
        busy_d   = 1'b0;

        if (FLUSH) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (START) begin
                        ctx_d = '{funct3: funct3_e'(FUNCT3), neg_a: neg1_c, neg_b: neg2_c};
                        cnt_d = '0;
                        if (div_zero_c) begin
                            result_d = FUNCT3[1] ? OPERAND1 : '1;
                            valid_d  = 1'b1;
                            state_d  = DONE;
                        end else if (div_ovf_c) begin
                            result_d = FUNCT3[1] ? '0 : OPERAND1;
                            valid_d  = 1'b1;
                            state_d  = DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, mag1_c};
                            opb_d   = mag2_c;
                            busy_d  = 1'b1;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d  = is_div(ctx_q.funct3) ? div_step_c : mul_step_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = fix_result_c;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opb_q        <= '0;
            ctx_q        <= '{funct3: OP_MUL, neg_a: 1'b0, neg_b: 1'b0};
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opb_q        <= opb_d;
            ctx_q        <= ctx_d;
            RESULT       <= result_d;
            RESULT_VALID <= valid_d;
            BUSY         <= busy_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (supported: 8, 16, 32, 64).
REQ-002 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  request; operands and FUNCT3 sampled on the same edge.
REQ-005 SHALL have port FUNCT3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port OPERAND1  input  XLEN  rs1 value (multiplicand / dividend).
REQ-007 SHALL have port OPERAND2  input  XLEN  rs2 value (multiplier / divisor).
REQ-008 SHALL have port FLUSH  input  1  kill in-flight op (branch taken in EX).
REQ-009 SHALL have port BUSY  output  1  op in progress; pipeline stalls IF/ID/EX while high.
REQ-010 SHALL have port RESULT_VALID  output  1  one-cycle pulse, RESULT valid.
REQ-011 SHALL have port RESULT  output  XLEN  registered result, held until next RESULT_VALID.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: START=1 and FLUSH=0 -> latch operands/op, convert signed operands to magnitudes, clear iteration counter, go CALC.
REQ-014 CALC: one radix-2 iteration per edge (shift-add multiply, restoring divide, 2*XLEN-bit accumulator); after XLEN iterations go FIX.
REQ-015 FIX: apply sign correction (two's-complement negate per op signedness), select low/high half or quotient/remainder, register RESULT, go DONE.
REQ-016 DONE: RESULT_VALID=1 for exactly this cycle; next edge go IDLE, or accept a new START directly (DONE counts as idle for acceptance).
REQ-017 Latency: RESULT_VALID SHALL be high in the cycle after the (XLEN+2)th rising edge counting the START-sampling edge as edge 1 (XLEN=32: 34th edge).
REQ-018 BUSY SHALL be 1 in CALC and FIX, 0 in IDLE and DONE.
REQ-019 START while BUSY=1 SHALL be ignored; no queuing.
REQ-020 Divide by zero: quotient all-ones, remainder = OPERAND1; bypasses CALC/FIX, IDLE -> DONE in one edge.
REQ-021 Signed overflow (DIV/REM, OPERAND1 = most negative, OPERAND2 = -1): quotient = OPERAND1, remainder 0; same one-edge fast path.
REQ-022 MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] of the exact signed*signed / signed*unsigned / unsigned*unsigned product; MUL SHALL return bits [XLEN-1:0].
REQ-023 REM/DIV sign: remainder takes dividend sign, quotient negative iff operand signs differ (truncation toward zero).
REQ-024 FLUSH=1 in any state SHALL force IDLE on next edge, suppress RESULT_VALID, leave RESULT unchanged; FLUSH with START in same cycle: FLUSH wins, op not accepted.
REQ-025 Operand inputs changing after the sampling edge SHALL not affect the result.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE, BUSY=0, RESULT_VALID=0, RESULT=0, counter and accumulators 0, overriding START and FLUSH, including mid-CALC.

Structure
REQ-027 FUNCT3 op codes and state encoding SHALL live in shared package muldiv_pkg, reused by control_unit.
REQ-028 Sign correction/half selection SHALL be one combinational sub-module muldiv_sign_fix; iteration datapath stays in muldiv_unit.
REQ-029 Counter width SHALL be clog2(XLEN)+1 bits; no multiplier/divider primitives inferred.

Verification
REQ-030 MUL 7 * -3 (XLEN=32), START one cycle -> RESULT_VALID on 34th edge, RESULT=0xFFFFFFEB, BUSY high 33 cycles.
REQ-031 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
REQ-033 DIVU 5 / 0 -> RESULT=0xFFFFFFFF one edge after START; REM 0x80000000 / 0xFFFFFFFF -> 0 one edge after START.
REQ-034 FLUSH at iteration 10 of DIV -> IDLE next edge, no RESULT_VALID, previous RESULT retained; new START next cycle completes normally.
REQ-035 RESET asserted mid-CALC, second START while BUSY, XLEN=8 MULHU 0xFF*0xFF -> 0xFE with latency 10 edges.
